fifo_write_arbiter: RTL and testbench

//  Shares the write port of one buffer FIFO between n_req producers (e.g. the UART RX path and a

---
 rtl/fifo_write_arbiter_if.sv | 36 +++
 rtl/fifo_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - producer and fifo write-side signal bundle for fifo_write_arbiter
//
// Purpose: groups the requester handshakes, the fifo write port and the grant status.
// Ports (slave = arbiter side):
//   req_valid/req_data/req_last  in   per-requester beat, requester i data at [i*width +: width]
//   req_ready                    out  per-requester accept
//   fifo_full                    in   fifo write side full
//   fifo_write_enable/_data_in   out  fifo write strobe and data
//   grant_id                     out  registered index of the granted requester
//   busy                         out  high while a grant is held
interface fifo_write_arbiter_if #(
  parameter int width = 8,
  parameter int n_req = 2
);
  localparam int gid_w = (n_req > 1) ? $clog2(n_req) : 1;

  logic [n_req-1:0]       req_valid;
  logic [n_req*width-1:0] req_data;
  logic [n_req-1:0]       req_last;
  logic [n_req-1:0]       req_ready;
  logic                   fifo_full;
  logic                   fifo_write_enable;
  logic [width-1:0]       fifo_data_in;
  logic [gid_w-1:0]       grant_id;
  logic                   busy;

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_write_enable, fifo_data_in, grant_id, busy
  );

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_write_enable, fifo_data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - packet-atomic round-robin arbiter for one fifo write port
//
// Purpose: shares a single fifo write port between n_req producers. A granted producer keeps
// the port until its last beat, max_burst accepted beats, or timeout cycles without an accept.
// Ports:
//   clock   in  rising-edge clock
//   resetn  in  asynchronous active-low reset
//   bus     slave modport of fifo_write_arbiter_if (requesters, fifo write side, status)
module fifo_write_arbiter #(
  parameter int width     = 8,
  parameter int n_req     = 2,
  parameter int max_burst = 4,
  parameter int timeout   = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  fifo_write_arbiter_if.slave  bus
);

  localparam int gid_w = (n_req > 1) ? $clog2(n_req) : 1;
  localparam int bc_w  = $clog2(max_burst + 1);
  localparam int ic_w  = (timeout > 1) ? $clog2(timeout) : 1;

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [gid_w-1:0]   rr_ptr_q, rr_ptr_d;
  logic [gid_w-1:0]   grant_id_q, grant_id_d;
  logic [bc_w-1:0]    beat_cnt_q, beat_cnt_d;
  logic [ic_w-1:0]    idle_cnt_q, idle_cnt_d;

  logic               g_valid, g_last;
  logic [width-1:0]   g_data;
  logic [gid_w-1:0]   pick, cand;
  logic               pick_found;
  logic               accept;

  logic [n_req-1:0]   req_ready;
  logic               fifo_we;
  logic [width-1:0]   fifo_data;
  logic               busy;

  // Signals of the currently granted requester.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < n_req; i++) begin
      if (grant_id_q == gid_w'(i)) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[i*width +: width];
      end
    end
  end

  // Round-robin search starting just after the last granted index, wrapping at n_req.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= n_req; k++) begin
      cand = gid_w'((int'(rr_ptr_q) + k) % n_req);
      if (!pick_found && bus.req_valid[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  assign accept = (state_q == BURST) && g_valid && !bus.fifo_full;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= gid_w'(n_req - 1);
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BURST;
          grant_id_d = pick;
          rr_ptr_d   = pick;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          idle_cnt_d = '0;
          // A burst-cap cut leaves the packet open; the producer resumes on its next grant.
          if (g_last || (beat_cnt_q == bc_w'(max_burst - 1))) begin
            state_d = IDLE;
          end
        end else begin
          // Stalls on fifo_full count toward the timeout just like an absent valid.
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_q == ic_w'(timeout - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: only the granted requester ever sees ready, so other producers' data never reaches the fifo.
  always_comb begin
    req_ready = '0;
    fifo_we   = 1'b0;
    fifo_data = '0;
    busy      = 1'b0;
    if (state_q == BURST) begin
      busy      = 1'b1;
      fifo_we   = g_valid && !bus.fifo_full;
      fifo_data = g_data;
      for (int i = 0; i < n_req; i++) begin
        req_ready[i] = (grant_id_q == gid_w'(i)) && !bus.fifo_full;
      end
    end
  end

  assign bus.req_ready         = req_ready;
  assign bus.fifo_write_enable = fifo_we;
  assign bus.fifo_data_in      = fifo_data;
  assign bus.grant_id          = grant_id_q;
  assign bus.busy              = busy;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

  localparam int W    = 8;
  localparam int N    = 2;
  localparam int MAXB = 4;
  localparam int TMO  = 16;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  fifo_write_arbiter_if #(.width(W), .n_req(N)) bus ();

  fifo_write_arbiter #(.width(W), .n_req(N), .max_burst(MAXB), .timeout(TMO)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  beat_t       pq[N][$];
  logic [N-1:0] acc;
  bit          rand_gaps;
  int          full_pct;
  bit          full_pat[$];
  bit          mon_en, model_en;
  logic [8:0]  sb_q[$];
  logic [8:0]  sb_exp;
  int          wr_cyc[$];
  int          cyc = 0;
  int          start_cyc;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model state.
  bit m_busy;
  int m_g, m_ptr, m_beats, m_idle;

  task automatic model_step();
    logic [N-1:0]   v, l;
    logic [N*W-1:0] d;
    bit             f, we;
    logic [W-1:0]   gd;
    v  = bus.req_valid;
    l  = bus.req_last;
    d  = bus.req_data;
    f  = bus.fifo_full;
    gd = d[m_g*W +: W];
    we = m_busy && v[m_g] && !f;
    check("m_busy", bus.busy, m_busy);
    if (m_busy) check("m_gid", bus.grant_id, m_g);
    check("m_ready", bus.req_ready, (m_busy && !f) ? (1 << m_g) : 0);
    check("m_we", bus.fifo_write_enable, we);
    if (we) sb_q.push_back({1'(m_g), gd});
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (m_ptr + k) % N;
        if (!m_busy && v[idx]) begin
          m_busy = 1; m_g = idx; m_ptr = idx; m_beats = 0; m_idle = 0;
        end
      end
    end else if (we) begin
      m_beats++;
      m_idle = 0;
      if (l[m_g] || m_beats == MAXB) m_busy = 0;
    end else begin
      m_idle++;
      if (m_idle == TMO) m_busy = 0;
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (model_en) model_step();
    if (mon_en) begin
      if (bus.fifo_full) begin
        check("stall_we", bus.fifo_write_enable, 0);
        check("stall_ready", bus.req_ready, 0);
      end
      if (bus.fifo_write_enable) begin
        wr_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_extra: got write %0h, expected none", {bus.grant_id, bus.fifo_data_in});
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_write", {bus.grant_id, bus.fifo_data_in}, sb_exp);
        end
      end
    end
  end

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      logic on;
      on = (pq[i].size() > 0) && (!rand_gaps || $urandom_range(0, 3) != 0);
      bus.req_valid[i]         = on;
      bus.req_data[i*W +: W]   = on ? pq[i][0].d : 8'($urandom);
      bus.req_last[i]          = on ? pq[i][0].l : 1'b0;
    end
    if (full_pat.size() > 0) bus.fifo_full = full_pat.pop_front();
    else bus.fifo_full = (full_pct > 0) && ($urandom_range(0, 99) < full_pct);
  endtask

  task automatic drive_cycle();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    apply_inputs();
  endtask

  task automatic sample_cycle();
    @(negedge clock);
    acc = bus.req_valid & bus.req_ready;
  endtask

  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      drive_cycle();
      if (c == 0) start_cyc = cyc;
      sample_cycle();
    end
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) pq[i].delete();
    full_pat.delete();
    sb_q.delete();
    wr_cyc.delete();
    acc = '0;
    rand_gaps = 0; full_pct = 0; mon_en = 0; model_en = 0;
    m_busy = 0; m_g = 0; m_ptr = N - 1; m_beats = 0; m_idle = 0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    resetn = 1'b0;
    clear_env();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic push_pkt(input int r, input logic [7:0] base, input int len, input int last_at);
    for (int j = 0; j < len; j++) pq[r].push_back('{d: base + 8'(j), l: (j == last_at)});
  endtask

  typedef struct packed {
    logic [1:0] v; logic [1:0] l; logic [7:0] d0; logic [7:0] d1; logic f;
    logic [1:0] rdy; logic we; logic [7:0] dat; logic busy; logic gid;
  } vec_t;
  vec_t vt[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard, total;

    vt[0]  = '{2'b01, 2'b00, 8'h11, 8'h22, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{2'b11, 2'b01, 8'h12, 8'h22, 1'b0, 2'b01, 1'b1, 8'h12, 1'b1, 1'b0};
    vt[2]  = '{2'b10, 2'b00, 8'h13, 8'h23, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[3]  = '{2'b10, 2'b10, 8'h13, 8'h24, 1'b1, 2'b00, 1'b0, 8'h24, 1'b1, 1'b1};
    vt[4]  = '{2'b10, 2'b10, 8'h13, 8'h25, 1'b0, 2'b10, 1'b1, 8'h25, 1'b1, 1'b1};
    vt[5]  = '{2'b00, 2'b00, 8'h14, 8'h26, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[6]  = '{2'b01, 2'b00, 8'h30, 8'h40, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[7]  = '{2'b00, 2'b00, 8'h31, 8'h41, 1'b0, 2'b01, 1'b0, 8'h31, 1'b1, 1'b0};
    vt[8]  = '{2'b11, 2'b00, 8'h32, 8'h42, 1'b0, 2'b01, 1'b1, 8'h32, 1'b1, 1'b0};
    vt[9]  = '{2'b01, 2'b01, 8'h33, 8'h43, 1'b1, 2'b00, 1'b0, 8'h33, 1'b1, 1'b0};
    vt[10] = '{2'b01, 2'b01, 8'h34, 8'h44, 1'b0, 2'b01, 1'b1, 8'h34, 1'b1, 1'b0};
    vt[11] = '{2'b00, 2'b00, 8'h35, 8'h45, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};

    clear_env();
    #2;
    check("por_ready", bus.req_ready, 0);
    check("por_we", bus.fifo_write_enable, 0);
    check("por_data", bus.fifo_data_in, 0);
    check("por_busy", bus.busy, 0);
    check("por_gid", bus.grant_id, 0);

    // Table-driven cycle vectors.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      @(posedge clock);
      #1;
      bus.req_valid = vt[r].v;
      bus.req_last  = vt[r].l;
      bus.req_data  = {vt[r].d1, vt[r].d0};
      bus.fifo_full = vt[r].f;
      @(negedge clock);
      check($sformatf("vec%0d_ready", r), bus.req_ready, vt[r].rdy);
      check($sformatf("vec%0d_we", r), bus.fifo_write_enable, vt[r].we);
      check($sformatf("vec%0d_data", r), bus.fifo_data_in, vt[r].dat);
      check($sformatf("vec%0d_busy", r), bus.busy, vt[r].busy);
      check($sformatf("vec%0d_gid", r), bus.grant_id, vt[r].gid);
    end

    // Round-robin with single-beat packets.
    do_reset();
    push_pkt(0, 8'hA0, 1, 0); push_pkt(0, 8'hA1, 1, 0);
    push_pkt(1, 8'hB0, 1, 0); push_pkt(1, 8'hB1, 1, 0);
    sb_q = '{{1'b0, 8'hA0}, {1'b1, 8'hB0}, {1'b0, 8'hA1}, {1'b1, 8'hB1}};
    mon_en = 1;
    run_cycles(10);
    check("rr_count", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) begin
      check("rr_first_latency", wr_cyc[0] - start_cyc, 1);
      for (int j = 1; j < 4; j++) check($sformatf("rr_gap%0d", j), wr_cyc[j] - wr_cyc[j-1], 2);
    end
    check("rr_drain", sb_q.size(), 0);

    // Burst cap splits a 6-beat packet around the other requester.
    do_reset();
    push_pkt(0, 8'hA0, 6, 5);
    push_pkt(1, 8'hB0, 1, 0);
    sb_q = '{{1'b0, 8'hA0}, {1'b0, 8'hA1}, {1'b0, 8'hA2}, {1'b0, 8'hA3},
             {1'b1, 8'hB0}, {1'b0, 8'hA4}, {1'b0, 8'hA5}};
    mon_en = 1;
    run_cycles(16);
    check("cap_count", wr_cyc.size(), 7);
    check("cap_drain", sb_q.size(), 0);

    // Three full cycles in the middle of a burst.
    do_reset();
    push_pkt(0, 8'hC0, 4, 3);
    full_pat = '{0, 0, 1, 1, 1};
    sb_q = '{{1'b0, 8'hC0}, {1'b0, 8'hC1}, {1'b0, 8'hC2}, {1'b0, 8'hC3}};
    mon_en = 1;
    run_cycles(12);
    check("stall_count", wr_cyc.size(), 4);
    if (wr_cyc.size() == 4) check("stall_gap", wr_cyc[1] - wr_cyc[0], 4);
    check("stall_drain", sb_q.size(), 0);

    // Granted requester goes silent; the waiting one gets the port after the timeout.
    do_reset();
    push_pkt(0, 8'hD0, 1, 9);
    push_pkt(1, 8'hE0, 1, 0);
    sb_q = '{{1'b0, 8'hD0}, {1'b1, 8'hE0}};
    mon_en = 1;
    run_cycles(24);
    check("tmo_count", wr_cyc.size(), 2);
    if (wr_cyc.size() == 2) check("tmo_gap", wr_cyc[1] - wr_cyc[0], 2 + TMO);
    check("tmo_drain", sb_q.size(), 0);

    // Reset asserted mid-burst with both requesters valid.
    do_reset();
    push_pkt(0, 8'h50, 1, 0); push_pkt(0, 8'h51, 1, 0);
    push_pkt(1, 8'h60, 3, 2);
    run_cycles(4);
    drive_cycle();
    check("rst_pre_busy", bus.busy, 1);
    check("rst_pre_gid", bus.grant_id, 1);
    resetn = 1'b0;
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_we", bus.fifo_write_enable, 0);
    check("rst_data", bus.fifo_data_in, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_gid", bus.grant_id, 0);
    clear_env();
    push_pkt(0, 8'h70, 1, 0);
    push_pkt(1, 8'h80, 1, 0);
    apply_inputs();
    @(posedge clock);
    #1;
    resetn = 1'b1;
    sample_cycle();
    drive_cycle();
    check("rst_post_busy", bus.busy, 1);
    check("rst_post_gid", bus.grant_id, 0);
    check("rst_post_ready", bus.req_ready, 2'b01);

    // Random traffic against the reference model.
    do_reset();
    total = 0;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < 25; p++) begin
        int len = $urandom_range(1, 6);
        for (int b = 0; b < len; b++) pq[i].push_back('{d: 8'($urandom), l: (b == len - 1)});
        total += len;
      end
    end
    rand_gaps = 1; full_pct = 25; model_en = 1; mon_en = 1;
    guard = 0;
    while ((pq[0].size() > 0 || pq[1].size() > 0 || m_busy) && guard < 5000) begin
      drive_cycle();
      sample_cycle();
      guard++;
    end
    check("rand_done", (pq[0].size() == 0) && (pq[1].size() == 0), 1);
    run_cycles(3);
    check("rand_beats", wr_cyc.size(), total);
    check("rand_drain", sb_q.size(), 0);
    model_en = 0; mon_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
